// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - request/response bundle between clients and the shared multiplier arbiter
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [15:0]          resp_product;
    logic [ID_W-1:0]      resp_id;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_product, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_product, resp_id
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one 8x8 multiplier with tagged, backpressured results
module multiplier_fast (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] product_o
);
    assign product_o = {8'h00, a_i} * {8'h00, b_i};
endmodule

module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_arbiter_if.slave bus,
    output logic                busy,
    output logic [15:0]         op_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [7:0]         a_q, a_d, b_q, b_d;
    logic [15:0]        product_q, product_d;
    logic [15:0]        op_count_q, op_count_d;
    logic [15:0]        mul_product;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               any_req;
    logic               accept;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        winner  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!any_req && bus.req_valid[idx]) begin
                any_req = 1'b1;
                winner  = ID_W'(idx);
            end
        end
        grant = any_req ? (NUM_REQ'(1) << winner) : '0;
    end

    // Gating with rst_n keeps the grant low while reset is held.
    assign bus.req_ready = (state_q == S_IDLE && rst_n) ? grant : '0;
    assign accept        = (state_q == S_IDLE) && any_req;

    multiplier_fast u_mul (
        .a_i       (a_q),
        .b_i       (b_q),
        .product_o (mul_product)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        resp_id_d    = resp_id_q;
        a_d          = a_q;
        b_d          = b_q;
        product_d    = product_q;
        op_count_d   = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d          = bus.req_a[8*winner +: 8];
                    b_d          = bus.req_b[8*winner +: 8];
                    id_d         = winner;
                    last_grant_d = winner;
                    state_d      = S_MUL;
                end
            end
            S_MUL: begin
                product_d = mul_product;
                resp_id_d = id_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            resp_id_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            product_q    <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            resp_id_q    <= resp_id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            product_q    <= product_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_product = product_q;
    assign bus.resp_id      = resp_id_q;
    assign busy             = (state_q != S_IDLE);
    assign op_count         = op_count_q;
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one `multiplier_fast` instance (8x8 unsigned, combinational, 16-bit product) among NUM_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Registered operand and product stages; tagged response with valid/ready backpressure.
- Sits between client blocks and the multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ)), minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request strobe; held until accepted.
- req_ready  output  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i].
- req_a  input  8*NUM_REQ  packed multiplicands; requester i at [8*i+7:8*i].
- req_b  input  8*NUM_REQ  packed multipliers, same packing.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_product  output  16  a*b of the granted request.
- resp_id  output  ID_W  index of the requester that owns resp_product.
- busy  output  1  high in any state other than IDLE.
- op_count  output  16  completed operations; wraps modulo 2^16.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=0; resp_valid=0; resp_product=0; resp_id=0; busy=0; op_count=0.
  - last_grant=NUM_REQ-1, so requester 0 has highest priority after reset.
- IDLE:
  - req_ready is combinational from req_valid and last_grant.
  - Exactly one bit is set: the first requester with req_valid=1, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - req_ready=0 when no request is pending.
  - On accept: latch a_reg/b_reg from the winner's slice, latch id_reg=winner, set last_grant=winner, go to MUL.
- MUL (one cycle):
  - req_ready=0.
  - multiplier_fast is driven from a_reg/b_reg.
  - At the clock edge: resp_product <= product, resp_id <= id_reg; go to RESP.
- RESP:
  - resp_valid=1; resp_product and resp_id stable; req_ready=0.
  - When resp_ready=1 at the edge: resp_valid deasserts, op_count increments by 1, go to IDLE.
  - resp_product holds its last value until the next capture.
- Latency: acceptance at edge N -> resp_valid high after edge N+1. Peak throughput is one operation per 3 cycles when resp_ready is tied high.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants before it is served.
- Requests arriving in MUL/RESP stay pending and are not dropped. Requesters must hold req_a/req_b stable while req_valid=1 and not yet accepted.
- Arithmetic: unsigned, product is 16 bits with no truncation; 255*255 = 65025.
- Reset asserted mid-operation: the in-flight operation is discarded, no resp_valid is produced, and all state returns to reset values immediately.
- Deasserting req_valid without acceptance is permitted; that requester loses its turn without any grant being issued.
- resp_ready while resp_valid=0 is ignored.
- op_count wrap: 0xFFFF + 1 = 0x0000.

Test Plan:
- Single request: req_valid[0]=1, a=5, b=10, resp_ready=1 -> req_ready[0]=1 in the same cycle; resp_valid high 2 edges later; resp_product=50, resp_id=0; op_count=1.
- Contention: all four requesters valid, with a=i+1 and b=3 for requester i, held continuously -> grant order 0,1,2,3,0; products 3, 6, 9, 12, 3; each resp_id matches.
- Backpressure: requester 2 sends a=255, b=255; resp_ready held low for 5 cycles -> resp_valid, resp_product=65025 and resp_id=2 stay stable; req_ready=0 throughout; no new grant until resp_ready rises.
- Rotation after idle: grant requester 1, then assert requests 0 and 3 together -> requester 3 is granted before requester 0.
- Reset mid-op: assert rst_n=0 during MUL -> all outputs return to reset values asynchronously; after release, a request from requester 0 is granted first.
- Randomised check: 2000 operations with random a/b, random req_valid patterns and random resp_ready.
  - Every response must satisfy resp_product == a*b of the tagged requester.
  - No requester may be granted twice while another valid requester waits.
  - op_count must equal the number of completed responses.
